fast_square_bb_deframe: RTL and testbench

- Receive-side parser for the framed baseband stream emitted by the anchor comb/decimate chain.
- Stream format, one strobed I/Q sample pair per frame slot:
  - a header sample carrying a 32-bit reset count (I = bits 15:0, Q = bits 31:16);
  - a run of marker samples (I = Q = 16'h8000);
  - then continuous filtered data.
- The block locates the header, validates the marker run, forwards data samples with a strobe, and reports reset-count continuity and stream timeouts to host-side logic.

---
 rtl/fast_square_bb_deframe_pkg.sv | 13 +
 rtl/fast_square_run_detect.sv | 47 ++++
 rtl/fast_square_bb_deframe.sv | 141 ++++++++++++++
 tb/tb_fast_square_bb_deframe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fast_square_bb_deframe_pkg.sv
// Shared constants and state encoding for the baseband deframer.
package fast_square_bb_deframe_pkg;

    localparam logic [15:0] MARKER_WORD    = 16'h8000;
    localparam int          NOMINAL_PERIOD = 33;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_MARKER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

endpackage

// File: rtl/fast_square_run_detect.sv
// Marker comparator plus saturating run counter; reach pulses on the sample
// that brings the run up to MARKER_MIN.
module fast_square_run_detect
    import fast_square_bb_deframe_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MARKER_MIN = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [15:0]      i_in,
    input  logic [15:0]      q_in,
    output logic             is_marker,
    output logic [CNT_W-1:0] count,
    output logic             reach
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MARKER_MIN);
    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MARKER_MIN - 1);

    logic hit;

    assign hit       = strobe & enable;
    assign is_marker = (i_in == MARKER_WORD) && (q_in == MARKER_WORD);
    assign reach     = hit && is_marker && (count == MIN_M1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= MIN_VAL;
        end else if (hit) begin
            if (!is_marker)
                count <= '0;
            else if (count != CNT_MAX)
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fast_square_bb_deframe.sv
// Header/marker deframer: locks onto the framed baseband stream, forwards
// data one clock later and flags reset-count gaps and strobe timeouts.
//
// state  | meaning
// SEARCH | hunting for a marker run, latching non-markers as header candidate
// MARKER | run long enough; waiting for the first data sample
// DATA   | locked, forwarding samples, watching for an upstream restart
module fast_square_bb_deframe
    import fast_square_bb_deframe_pkg::*;
#(
    parameter int MARKER_MIN     = 16,
    parameter int TIMEOUT_CYCLES = 128,
    parameter int CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in_strobe,
    input  logic [15:0]      i_in,
    input  logic [15:0]      q_in,
    output logic             data_out_strobe,
    output logic [15:0]      i_out,
    output logic [15:0]      q_out,
    output logic             header_valid,
    output logic [31:0]      reset_count,
    output logic [CNT_W-1:0] marker_run,
    output logic             locked,
    output logic             missed_reset,
    output logic             timeout_err
);

    localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_TRIG = GAP_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_next;
    logic [GAP_W-1:0]   gap;
    logic [31:0]        candidate;
    logic               have_prev_count;
    logic               is_marker, shadow_marker;
    logic [CNT_W-1:0]   run_count, shadow_count;
    logic               run_reach, shadow_reach;
    logic               timeout, accept, restart, forward;

    assign timeout = !data_in_strobe && (gap == GAP_TRIG);

    fast_square_run_detect #(.CNT_W(CNT_W), .MARKER_MIN(MARKER_MIN)) u_run (
        .clock     (clock),
        .reset     (reset),
        .strobe    (data_in_strobe),
        .enable    (state != ST_DATA),
        .clear     (timeout),
        .load      (restart),
        .i_in      (i_in),
        .q_in      (q_in),
        .is_marker (is_marker),
        .count     (run_count),
        .reach     (run_reach)
    );

    fast_square_run_detect #(.CNT_W(CNT_W), .MARKER_MIN(MARKER_MIN)) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .strobe    (data_in_strobe),
        .enable    (state == ST_DATA),
        .clear     (timeout | restart),
        .load      (1'b0),
        .i_in      (i_in),
        .q_in      (q_in),
        .is_marker (shadow_marker),
        .count     (shadow_count),
        .reach     (shadow_reach)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            state <= ST_SEARCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = ST_SEARCH;
        end else if (data_in_strobe) begin
            case (state)
                ST_SEARCH: if (run_reach)    state_next = ST_MARKER;
                ST_MARKER: if (!is_marker)   state_next = ST_DATA;
                ST_DATA:   if (shadow_reach) state_next = ST_MARKER;
                default:                     state_next = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        accept  = data_in_strobe && (state == ST_MARKER) && !is_marker;
        restart = shadow_reach && (state == ST_DATA);
        forward = accept || (data_in_strobe && (state == ST_DATA) && !shadow_reach);
        locked  = (state == ST_DATA);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out_strobe <= 1'b0;
            i_out           <= '0;
            q_out           <= '0;
            header_valid    <= 1'b0;
            reset_count     <= '0;
            marker_run      <= '0;
            missed_reset    <= 1'b0;
            timeout_err     <= 1'b0;
            candidate       <= '0;
            have_prev_count <= 1'b0;
            // Start saturated so an idle link after reset is not a timeout.
            gap             <= GAP_MAX;
        end else begin
            data_out_strobe <= forward;
            header_valid    <= accept;
            if (forward) begin
                i_out <= i_in;
                q_out <= q_in;
            end
            if (data_in_strobe)
                gap <= '0;
            else if (gap != GAP_MAX)
                gap <= gap + 1'b1;
            if (data_in_strobe && !shadow_marker)
                candidate <= {q_in, i_in};
            if (accept) begin
                reset_count     <= candidate;
                marker_run      <= run_count;
                have_prev_count <= 1'b1;
                if (have_prev_count && (candidate != reset_count + 32'd1))
                    missed_reset <= 1'b1;
            end
            if (timeout)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fast_square_bb_deframe.sv
// Directed bench for the deframer with a sample-level behavioural model.
module tb_fast_square_bb_deframe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        data_in_strobe = 1'b0;
    logic [15:0] i_in = '0, q_in = '0;
    logic        data_out_strobe, header_valid, locked, missed_reset, timeout_err;
    logic [15:0] i_out, q_out;
    logic [31:0] reset_count;
    logic [7:0]  marker_run;

    fast_square_bb_deframe dut (
        .clock(clock), .reset(reset), .data_in_strobe(data_in_strobe),
        .i_in(i_in), .q_in(q_in), .data_out_strobe(data_out_strobe),
        .i_out(i_out), .q_out(q_out), .header_valid(header_valid),
        .reset_count(reset_count), .marker_run(marker_run), .locked(locked),
        .missed_reset(missed_reset), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0;
    int n_hdr = 0, n_fwd = 0, n_mkfwd = 0;
    bit started = 0;

    // model state: mode 0 = hunting, 1 = run confirmed, 2 = locked
    int          m_mode, m_run, m_shadow, m_gap;
    bit          m_armed, m_have;
    logic [31:0] m_cand;
    logic        e_fwd, e_hdr, e_locked, e_missed, e_tout;
    logic [31:0] e_data, e_rc;
    int          e_run;

    localparam logic [31:0] MK = 32'h8000_8000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_shadow = 0; m_gap = 0; m_armed = 0; m_have = 0;
        m_cand = '0; e_fwd = 0; e_hdr = 0; e_locked = 0; e_missed = 0; e_tout = 0;
        e_data = '0; e_rc = '0; e_run = 0; started = 1;
    endtask

    task automatic fwd(input logic [31:0] s);
        e_fwd = 1; e_data = s;
    endtask

    task automatic model_step(input logic stb, input logic [31:0] s);
        bit mk;
        mk = (s == MK);
        e_fwd = 0; e_hdr = 0;
        if (!stb) begin
            if (m_armed && m_gap < 128) begin
                m_gap++;
                if (m_gap == 128) begin
                    e_tout = 1; m_mode = 0; m_run = 0; m_shadow = 0;
                end
            end
        end else begin
            m_gap = 0; m_armed = 1;
            case (m_mode)
                0: if (!mk) begin m_cand = s; m_run = 0; end
                   else begin m_run = sat(m_run + 1); if (m_run == 16) m_mode = 1; end
                1: if (mk) m_run = sat(m_run + 1);
                   else begin
                       e_hdr = 1;
                       if (m_have && m_cand != e_rc + 32'd1) e_missed = 1;
                       e_rc = m_cand; e_run = m_run; m_have = 1; m_mode = 2;
                       fwd(s); m_cand = s; m_run = 0;
                   end
                default: if (mk) begin
                       m_shadow++;
                       if (m_shadow == 16) begin m_mode = 1; m_run = 16; m_shadow = 0; end
                       else fwd(s);
                   end else begin
                       m_shadow = 0; m_cand = s; fwd(s);
                   end
            endcase
        end
        e_locked = (m_mode == 2);
    endtask

    always begin
        @(posedge clock);
        #1;
        if (started) begin
            chk("data_out_strobe", 32'(data_out_strobe), 32'(e_fwd));
            chk("data_out", {q_out, i_out}, e_data);
            chk("header_valid", 32'(header_valid), 32'(e_hdr));
            chk("reset_count", reset_count, e_rc);
            chk("marker_run", 32'(marker_run), 32'(e_run));
            chk("locked", 32'(locked), 32'(e_locked));
            chk("missed_reset", 32'(missed_reset), 32'(e_missed));
            chk("timeout_err", 32'(timeout_err), 32'(e_tout));
            if (header_valid) n_hdr++;
            if (data_out_strobe) n_fwd++;
            if (data_out_strobe && {q_out, i_out} == MK) n_mkfwd++;
        end
    end

    task automatic cycle(input logic rb, input logic stb, input logic [31:0] s);
        @(negedge clock);
        reset = rb; data_in_strobe = stb; i_in = s[15:0]; q_in = s[31:16];
        if (!rb) model_reset();
        else model_step(stb, s);
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [31:0] s, input int sp);
        cycle(1'b1, 1'b1, s);
        repeat (sp - 1) cycle(1'b1, 1'b0, s);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 32'h0);
    endtask

    task automatic frame(input logic [31:0] hdr, input int nmk, input int sp);
        send(hdr, sp);
        repeat (nmk) send(MK, sp);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        n_hdr = 0; n_fwd = 0; n_mkfwd = 0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst locked", 32'(locked), 32'd0);
        chk("rst reset_count", reset_count, 32'd0);

        // clean frame at nominal spacing
        frame(32'h0001_0003, 201, 33);
        cycle(1'b1, 1'b1, 32'h0000_0001);
        chk("clean first out strobe", 32'(data_out_strobe), 32'd1);
        chk("clean first i_out", 32'(i_out), 32'd1);
        idle(32);
        send(32'h0000_0002, 33);
        send(32'h0000_0003, 33);
        chk("clean hdr pulses", 32'(n_hdr), 32'd1);
        chk("clean reset_count", reset_count, 32'h0001_0003);
        chk("clean marker_run", 32'(marker_run), 32'd201);
        chk("clean locked", 32'(locked), 32'd1);
        chk("clean fwd count", 32'(n_fwd), 32'd3);

        // short runs: 10 and 15 markers rejected, exactly 16 accepted
        do_reset();
        frame(32'h0000_0042, 10, 2);
        send(32'h1, 2); send(32'h2, 2); send(32'h3, 2);
        frame(32'h0000_0043, 15, 2);
        send(32'h7, 2);
        chk("short hdr pulses", 32'(n_hdr), 32'd0);
        chk("short locked", 32'(locked), 32'd0);
        chk("short fwd count", 32'(n_fwd), 32'd0);
        frame(32'h0000_0055, 16, 2);
        send(32'h9, 2);
        chk("min run locked", 32'(locked), 32'd1);
        chk("min run marker_run", 32'(marker_run), 32'd16);
        chk("min run reset_count", reset_count, 32'h55);

        // restart while in DATA
        do_reset();
        frame(32'd5, 20, 2);
        send(32'h1111, 2); send(32'h2222, 2);
        frame(32'd6, 201, 2);
        send(32'h3333, 2);
        chk("restart markers forwarded", 32'(n_mkfwd), 32'd15);
        chk("restart hdr pulses", 32'(n_hdr), 32'd2);
        chk("restart reset_count", reset_count, 32'd6);
        chk("restart marker_run", 32'(marker_run), 32'd201);
        chk("restart missed", 32'(missed_reset), 32'd0);

        // count jump 5 -> 8 -> 9
        do_reset();
        frame(32'd5, 16, 2); send(32'h10, 2);
        frame(32'd8, 16, 2); send(32'h11, 2);
        chk("jump missed", 32'(missed_reset), 32'd1);
        frame(32'd9, 16, 2); send(32'h12, 2);
        chk("jump sticky", 32'(missed_reset), 32'd1);
        chk("jump reset_count", reset_count, 32'd9);

        // timeout boundary
        send(32'h0A, 1);
        idle(127);
        send(32'h0B, 1);
        chk("gap128 no timeout", 32'(timeout_err), 32'd0);
        chk("gap128 locked", 32'(locked), 32'd1);
        idle(128);
        chk("timeout err", 32'(timeout_err), 32'd1);
        chk("timeout locked", 32'(locked), 32'd0);
        idle(300);
        send(32'h0C, 2);
        chk("timeout no fwd", 32'(locked), 32'd0);

        // reset mid-DATA, then relock without a previous count
        frame(32'd20, 16, 2); send(32'h13, 2);
        chk("pre-reset locked", 32'(locked), 32'd1);
        do_reset();
        chk("mid rst strobe", 32'(data_out_strobe), 32'd0);
        chk("mid rst data", {q_out, i_out}, 32'd0);
        chk("mid rst reset_count", reset_count, 32'd0);
        chk("mid rst marker_run", 32'(marker_run), 32'd0);
        chk("mid rst locked", 32'(locked), 32'd0);
        chk("mid rst missed", 32'(missed_reset), 32'd0);
        chk("mid rst timeout", 32'(timeout_err), 32'd0);
        frame(32'd100, 16, 2); send(32'h14, 2);
        chk("relock locked", 32'(locked), 32'd1);
        chk("relock missed", 32'(missed_reset), 32'd0);
        chk("relock reset_count", reset_count, 32'd100);

        // header with no candidate straight after reset
        do_reset();
        repeat (17) send(MK, 2);
        send(32'h0000_0099, 2);
        chk("nocand reset_count", reset_count, 32'd0);
        chk("nocand marker_run", 32'(marker_run), 32'd17);
        chk("nocand locked", 32'(locked), 32'd1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
